// File: rtl/sequenciador_acoes.sv
// Action sequencer: cycles FRENTE/ESQUERDA/DIREITA/RE on each reset_mux rising edge,
// pre-empted by a timed reverse manoeuvre when the obstacle sensor fires.
module sequenciador_acoes #(
    parameter int RE_CICLOS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       liga,
    input  logic       reset_mux,
    input  logic       sensor_obstaculo,
    output logic [1:0] acao,
    output logic [1:0] motor_esq,
    output logic [1:0] motor_dir,
    output logic       limpa_contagem,
    output logic       em_desvio
);

    typedef enum logic [1:0] {
        PARADO  = 2'd0,
        EXECUTA = 2'd1,
        DESVIO  = 2'd2
    } estado_t;

    localparam logic [1:0] ACAO_FRENTE  = 2'd0;
    localparam logic [1:0] ACAO_DIREITA = 2'd2;
    localparam logic [1:0] ACAO_RE      = 2'd3;
    localparam logic [7:0] TIMER_CARGA  = 8'(RE_CICLOS - 1);

    estado_t    estado_q, estado_d;
    logic [1:0] acao_q, acao_d;
    logic [7:0] timer_q, timer_d;
    logic       reset_mux_ant_q;
    logic [1:0] motor_esq_q, motor_esq_d;
    logic [1:0] motor_dir_q, motor_dir_d;
    logic       limpa_q, limpa_d;
    logic       em_desvio_q, em_desvio_d;
    logic       avanco_s;

    assign avanco_s = reset_mux & ~reset_mux_ant_q;

    // State and output registers; edge-detector history resets high so a held request is not an advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q        <= PARADO;
            acao_q          <= 2'd0;
            timer_q         <= 8'd0;
            reset_mux_ant_q <= 1'b1;
            motor_esq_q     <= 2'b00;
            motor_dir_q     <= 2'b00;
            limpa_q         <= 1'b0;
            em_desvio_q     <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            acao_q          <= acao_d;
            timer_q         <= timer_d;
            reset_mux_ant_q <= reset_mux;
            motor_esq_q     <= motor_esq_d;
            motor_dir_q     <= motor_dir_d;
            limpa_q         <= limpa_d;
            em_desvio_q     <= em_desvio_d;
        end
    end

    // Next-state: liga=0 dominates, then obstacle, then advance
    always_comb begin
        estado_d = estado_q;
        acao_d   = acao_q;
        timer_d  = timer_q;
        limpa_d  = 1'b0;
        if (!liga) begin
            estado_d = PARADO;
            timer_d  = 8'd0;
        end else begin
            case (estado_q)
                PARADO: begin
                    estado_d = EXECUTA;
                    acao_d   = ACAO_FRENTE;
                    limpa_d  = 1'b1;
                end
                EXECUTA: begin
                    if (sensor_obstaculo && (acao_q != ACAO_RE)) begin
                        estado_d = DESVIO;
                        timer_d  = TIMER_CARGA;
                    end else if (avanco_s) begin
                        acao_d  = acao_q + 2'd1;
                        limpa_d = 1'b1;
                    end else begin
                        acao_d = acao_q;
                    end
                end
                DESVIO: begin
                    if (timer_q == 8'd0) begin
                        estado_d = EXECUTA;
                        acao_d   = ACAO_DIREITA;
                        limpa_d  = 1'b1;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
                default: begin
                    estado_d = PARADO;
                    timer_d  = 8'd0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs change on the same edge
    always_comb begin
        motor_esq_d = 2'b00;
        motor_dir_d = 2'b00;
        em_desvio_d = 1'b0;
        case (estado_d)
            PARADO: begin
                motor_esq_d = 2'b00;
                motor_dir_d = 2'b00;
            end
            EXECUTA: begin
                case (acao_d)
                    2'd0:    begin motor_esq_d = 2'b10; motor_dir_d = 2'b10; end
                    2'd1:    begin motor_esq_d = 2'b01; motor_dir_d = 2'b10; end
                    2'd2:    begin motor_esq_d = 2'b10; motor_dir_d = 2'b01; end
                    default: begin motor_esq_d = 2'b01; motor_dir_d = 2'b01; end
                endcase
            end
            DESVIO: begin
                motor_esq_d = 2'b01;
                motor_dir_d = 2'b01;
                em_desvio_d = 1'b1;
            end
            default: begin
                motor_esq_d = 2'b00;
                motor_dir_d = 2'b00;
            end
        endcase
    end

    assign acao           = acao_q;
    assign motor_esq      = motor_esq_q;
    assign motor_dir      = motor_dir_q;
    assign limpa_contagem = limpa_q;
    assign em_desvio      = em_desvio_q;

endmodule

// File: tb/tb_sequenciador_acoes.sv
// Scoreboard bench for sequenciador_acoes: every clear pulse is matched against a queued
// {acao, motor_esq, motor_dir} expectation; manoeuvre and reset behaviour checked directly.
module tb_sequenciador_acoes;

    logic       clk = 1'b0;
    logic       reset, liga, reset_mux, sensor_obstaculo;
    logic [1:0] acao, motor_esq, motor_dir;
    logic       limpa_contagem, em_desvio;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];

    sequenciador_acoes #(.RE_CICLOS(8)) dut (
        .clk(clk), .reset(reset), .liga(liga), .reset_mux(reset_mux),
        .sensor_obstaculo(sensor_obstaculo), .acao(acao), .motor_esq(motor_esq),
        .motor_dir(motor_dir), .limpa_contagem(limpa_contagem), .em_desvio(em_desvio)
    );

    always #5 clk = ~clk;

    // Hand table: FRENTE 10/10, ESQUERDA 01/10, DIREITA 10/01, RE 01/01
    function automatic logic [5:0] esperado(input logic [1:0] a);
        case (a)
            2'd0:    return {a, 2'b10, 2'b10};
            2'd1:    return {a, 2'b01, 2'b10};
            2'd2:    return {a, 2'b10, 2'b01};
            default: return {a, 2'b01, 2'b01};
        endcase
    endfunction

    task automatic chk(input string nome, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", nome, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulso(input logic [1:0] nova_acao);
        exp_q.push_back(esperado(nova_acao));
        reset_mux = 1'b1;
        tick();
        reset_mux = 1'b0;
        repeat (4) tick();
    endtask

    // Monitor: each clear pulse consumes one expectation
    always @(negedge clk) begin
        if (!reset && limpa_contagem) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL clear_pulse: unexpected pulse acao=%0d esq=%b dir=%b", acao, motor_esq, motor_dir);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if ({acao, motor_esq, motor_dir} !== e) begin
                    errors++;
                    $display("FAIL clear_pulse: got=%b expected=%b", {acao, motor_esq, motor_dir}, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; liga = 1'b0; reset_mux = 1'b1; sensor_obstaculo = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_state", {acao, motor_esq, motor_dir, limpa_contagem, em_desvio}, 8'h00);

        // Start with reset_mux already high: one clear, no advance
        exp_q.push_back(esperado(2'd0));
        tick();
        reset = 1'b0; liga = 1'b1;
        repeat (3) tick();
        reset_mux = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("start_no_advance", {2'b00, acao, motor_esq, motor_dir}, {2'b00, esperado(2'd0)});

        // Full cycle 1,2,3,0
        pulso(2'd1); pulso(2'd2); pulso(2'd3); pulso(2'd0);

        // Held request for 10 cycles gives one increment
        exp_q.push_back(esperado(2'd1));
        reset_mux = 1'b1;
        repeat (10) tick();
        reset_mux = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("held_one_step", {6'd0, acao}, 8'd1);
        pulso(2'd2); pulso(2'd3); pulso(2'd0);

        // Obstacle in FRENTE: 8 cycles of reverse, request inside is ignored, exit to DIREITA
        exp_q.push_back(esperado(2'd2));
        sensor_obstaculo = 1'b1;
        tick();
        sensor_obstaculo = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("desvio_active", {3'd0, em_desvio, motor_esq, motor_dir}, {3'd0, 1'b1, 4'b0101});
            if (j == 3) reset_mux = 1'b1;
            if (j == 4) reset_mux = 1'b0;
            tick();
        end
        @(negedge clk);
        chk("desvio_exit", {5'd0, em_desvio, acao}, {5'd0, 1'b0, 2'd2});
        repeat (3) tick();
        @(negedge clk);
        chk("after_desvio_acao", {6'd0, acao}, 8'd2);

        // Sensor ignored in RE
        pulso(2'd3);
        sensor_obstaculo = 1'b1;
        repeat (2) tick();
        sensor_obstaculo = 1'b0;
        @(negedge clk);
        chk("sensor_in_re", {5'd0, em_desvio, acao}, {5'd0, 1'b0, 2'd3});
        pulso(2'd0);

        // Collision: sensor wins, advance dropped
        exp_q.push_back(esperado(2'd2));
        reset_mux = 1'b1; sensor_obstaculo = 1'b1;
        tick();
        reset_mux = 1'b0; sensor_obstaculo = 1'b0;
        @(negedge clk);
        chk("collision", {5'd0, em_desvio, acao}, {5'd0, 1'b1, 2'd0});
        repeat (3) tick();

        // liga=0 mid-manoeuvre cancels it
        void'(exp_q.pop_back());
        liga = 1'b0;
        tick();
        @(negedge clk);
        chk("stop_in_desvio", {acao, motor_esq, motor_dir, limpa_contagem, em_desvio}, 8'h00);
        repeat (2) tick();
        exp_q.push_back(esperado(2'd0));
        liga = 1'b1;
        repeat (2) tick();
        pulso(2'd1);

        // Async reset during DESVIO with timer=4
        exp_q.push_back(esperado(2'd2));
        sensor_obstaculo = 1'b1;
        tick();
        sensor_obstaculo = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("pre_async_reset", {3'd0, em_desvio, motor_esq, motor_dir}, {3'd0, 1'b1, 4'b0101});
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", {acao, motor_esq, motor_dir, limpa_contagem, em_desvio}, 8'h00);
        exp_q.delete();
        liga = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("stays_parado", {acao, motor_esq, motor_dir, limpa_contagem, em_desvio}, 8'h00);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
